conv_frame_sequencer: RTL and testbench

//  Job-level controller for the 3x3 2D convolution engine (32x32 frame, 8b pixels, 22b signed results).

---
 rtl/conv_pkg.sv | 9 +
 rtl/conv_result_writer.sv | 40 ++++
 rtl/conv_frame_sequencer.sv | 111 +++++++++++
 tb/tb_conv_frame_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: frame geometry, data widths and sequencer state encoding for the conv engine
package conv_pkg;
  localparam int IMG_WIDTH = 32;
  localparam int IMG_HEIGHT = 32;
  localparam int PIX_W = 8;
  localparam int RES_W = 22;
  localparam int FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
  typedef enum logic [2:0] {IDLE, START, STREAM, WAIT_DONE, DRAIN, RESP} seq_state_t;
endpackage

// File: rtl/conv_result_writer.sv
// conv_result_writer: captures engine results into a registered result SRAM write port with a per-job cap
module conv_result_writer
  import conv_pkg::*;
#(
  parameter int AW = 16,
  parameter int MAX_RESULTS = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             cap_en,
  input  logic [AW-1:0]    dst_base,
  input  logic [RES_W-1:0] conv_result,
  input  logic             conv_result_valid,
  output logic             res_wr_en,
  output logic [AW-1:0]    res_wr_addr,
  output logic [RES_W-1:0] res_wr_data,
  output logic [10:0]      count,
  output logic             ovf
);
  logic hit, full;
  assign hit = cap_en && conv_result_valid;
  assign full = count == 11'(MAX_RESULTS);
  always_ff @(posedge clk)
    if (rst || clr) begin
      res_wr_en <= 1'b0;
      res_wr_addr <= '0;
      res_wr_data <= '0;
      count <= '0;
      ovf <= 1'b0;
    end else begin
      res_wr_en <= hit && !full;
      if (hit && !full) begin
        res_wr_addr <= dst_base + AW'(count);
        res_wr_data <= conv_result;
        count <= count + 11'd1;
      end
      if (hit && full) ovf <= 1'b1;
    end
endmodule

// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer: job-level controller that starts the conv engine, streams one frame and writes back results
module conv_frame_sequencer
  import conv_pkg::*;
#(
  parameter int AW = 16,
  parameter int DRAIN_CYCLES = 8,
  parameter int DONE_TIMEOUT = 64,
  parameter int MAX_RESULTS = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [AW-1:0]    job_src_base,
  input  logic [AW-1:0]    job_dst_base,
  input  logic [3:0]       job_gap,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [10:0]      resp_count,
  output logic [1:0]       resp_err,
  output logic             busy,
  output logic             mem_rd_en,
  output logic [AW-1:0]    mem_rd_addr,
  input  logic [PIX_W-1:0] mem_rd_data,
  output logic             conv_start,
  output logic [PIX_W-1:0] conv_pixel,
  output logic             conv_pixel_valid,
  input  logic [RES_W-1:0] conv_result,
  input  logic             conv_result_valid,
  input  logic             conv_done,
  output logic             res_wr_en,
  output logic [AW-1:0]    res_wr_addr,
  output logic [RES_W-1:0] res_wr_data
);
  localparam int IW = $clog2(FRAME_PIXELS);
  seq_state_t state, nxt;
  logic [AW-1:0] src, dst;
  logic [3:0] gap, gap_cnt;
  logic [IW-1:0] rd_idx;
  logic [15:0] cnt;
  logic [10:0] count;
  logic to_err, ovf, accept, rd_en, timeout;
  assign accept = state == IDLE && job_valid;
  assign rd_en = state == STREAM && gap_cnt == 4'd0;
  assign timeout = state == WAIT_DONE && !conv_done && cnt == 16'(DONE_TIMEOUT - 1);
  assign job_ready = state == IDLE;
  assign busy = state != IDLE;
  assign conv_start = state == START;
  assign mem_rd_en = rd_en;
  assign mem_rd_addr = rd_en ? src + AW'(rd_idx) : '0;
  assign conv_pixel = conv_pixel_valid ? mem_rd_data : '0;
  assign resp_valid = state == RESP;
  assign resp_count = resp_valid ? count : '0;
  assign resp_err = resp_valid ? {ovf, to_err} : '0;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = job_valid ? START : IDLE;
      START:     nxt = STREAM;
      STREAM:    nxt = (rd_en && rd_idx == IW'(FRAME_PIXELS - 1)) ? WAIT_DONE : STREAM;
      WAIT_DONE: nxt = (conv_done || timeout) ? DRAIN : WAIT_DONE;
      DRAIN:     nxt = cnt == 16'(DRAIN_CYCLES - 1) ? RESP : DRAIN;
      RESP:      nxt = resp_ready ? IDLE : RESP;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      src <= '0;
      dst <= '0;
      gap <= '0;
      gap_cnt <= '0;
      rd_idx <= '0;
      cnt <= '0;
      to_err <= 1'b0;
      conv_pixel_valid <= 1'b0;
    end else begin
      state <= nxt;
      conv_pixel_valid <= rd_en;
      // one shared counter times WAIT_DONE and DRAIN; it restarts on every state change
      cnt <= (nxt != state) ? '0 : cnt + 16'd1;
      if (accept) begin
        src <= job_src_base;
        dst <= job_dst_base;
        gap <= job_gap;
        rd_idx <= '0;
        gap_cnt <= '0;
        to_err <= 1'b0;
      end
      if (rd_en) begin
        rd_idx <= rd_idx + IW'(1);
        gap_cnt <= gap;
      end else if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
      if (timeout) to_err <= 1'b1;
    end
  conv_result_writer #(.AW(AW), .MAX_RESULTS(MAX_RESULTS)) u_writer (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .cap_en(state inside {STREAM, WAIT_DONE, DRAIN}),
    .dst_base(dst),
    .conv_result(conv_result),
    .conv_result_valid(conv_result_valid),
    .res_wr_en(res_wr_en),
    .res_wr_addr(res_wr_addr),
    .res_wr_data(res_wr_data),
    .count(count),
    .ovf(ovf)
  );
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb_conv_frame_sequencer: directed jobs against SRAM and conv engine models with scenario tasks
module tb_conv_frame_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic job_valid = 1'b0, job_ready, resp_valid, resp_ready = 1'b0, busy;
  logic [15:0] job_src_base = '0, job_dst_base = '0, mem_rd_addr, res_wr_addr;
  logic [3:0] job_gap = '0;
  logic [10:0] resp_count;
  logic [1:0] resp_err;
  logic mem_rd_en, conv_start, conv_pixel_valid, res_wr_en;
  logic [7:0] mem_rd_data = '0, conv_pixel;
  logic [21:0] conv_result = '0, res_wr_data;
  logic conv_result_valid = 1'b0, conv_done = 1'b0;
  int tests = 0, fails = 0, cyc = 0, acc = 0;
  logic [15:0] exp_src = '0, exp_dst = '0, prev_addr = '0, last_wr = '0;
  int exp_gap = 0, eng_nres = 0;
  logic eng_done_en = 1'b0, eng_act = 1'b0, done_sent = 1'b0;
  int eng_t = 0, eng_i = 0;
  int rd_cnt = 0, pv_cnt = 0, wr_cnt = 0, rd_bad = 0, gap_bad = 0, pix_bad = 0, wr_bad = 0;
  int pv_run = 0, pv_max = 0, resp_cyc = -1, start_cyc = -1, first_rd = -1, pv_first = -1, last_rd = 0;

  conv_frame_sequencer dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_src_base(job_src_base), .job_dst_base(job_dst_base), .job_gap(job_gap),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_count(resp_count), .resp_err(resp_err),
    .busy(busy), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .conv_start(conv_start), .conv_pixel(conv_pixel), .conv_pixel_valid(conv_pixel_valid),
    .conv_result(conv_result), .conv_result_valid(conv_result_valid), .conv_done(conv_done),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_rd_addr[7:0];

  function automatic logic [21:0] rv(input int i);
    return 22'(i * 4099 - 2000000);
  endfunction

  // observe the DUT and play the engine: results from 10 cycles after start, done after the last pixel
  always @(negedge clk) begin
    if (conv_start) begin
      rd_cnt = 0; pv_cnt = 0; wr_cnt = 0; rd_bad = 0; gap_bad = 0; pix_bad = 0; wr_bad = 0;
      pv_run = 0; pv_max = 0; resp_cyc = -1; start_cyc = cyc; first_rd = -1; pv_first = -1;
      eng_act = 1'b1; eng_t = 0; eng_i = 0; done_sent = 1'b0;
    end
    if (conv_pixel_valid) begin
      if (pv_cnt == 0) pv_first = cyc;
      if (conv_pixel !== prev_addr[7:0]) pix_bad++;
      pv_cnt++; pv_run++;
      if (pv_run > pv_max) pv_max = pv_run;
    end else pv_run = 0;
    prev_addr = mem_rd_addr;
    if (mem_rd_en) begin
      if (mem_rd_addr !== 16'(exp_src + rd_cnt)) rd_bad++;
      if (rd_cnt == 0) first_rd = cyc;
      else if (cyc - last_rd != exp_gap + 1) gap_bad++;
      last_rd = cyc; rd_cnt++;
    end
    if (res_wr_en) begin
      if (res_wr_addr !== 16'(exp_dst + wr_cnt) || res_wr_data !== rv(wr_cnt)) wr_bad++;
      last_wr = res_wr_addr; wr_cnt++;
    end
    if (resp_valid && resp_cyc < 0) resp_cyc = cyc;
    conv_result_valid = 1'b0; conv_done = 1'b0;
    if (rst) eng_act = 1'b0;
    if (eng_act) begin
      eng_t++;
      if (eng_t >= 10 && eng_i < eng_nres) begin
        conv_result_valid = 1'b1; conv_result = rv(eng_i); eng_i++;
      end
      if (eng_done_en && !done_sent && pv_cnt == 1024 && eng_i == eng_nres) begin
        conv_done = 1'b1; done_sent = 1'b1;
      end
    end
  end

  task automatic start_job(input logic [15:0] s, input logic [15:0] d, input int g, input int n, input logic den);
    @(posedge clk); #1;
    exp_src = s; exp_dst = d; exp_gap = g; eng_nres = n; eng_done_en = den;
    job_src_base = s; job_dst_base = d; job_gap = 4'(g); job_valid = 1'b1;
    @(negedge clk);
    tests++; if (job_ready !== 1'b1) begin fails++; $display("FAIL job_ready_at_accept: got %b want 1", job_ready); end
    acc = cyc;
    @(posedge clk); #1 job_valid = 1'b0;
  endtask

  task automatic wait_resp(input int bound);
    for (int i = 0; i < bound && !resp_valid; i++) @(negedge clk);
    tests++; if (resp_valid !== 1'b1) begin fails++; $display("FAIL resp_timeout: resp_valid %b after %0d cycles", resp_valid, bound); end
    @(negedge clk);
  endtask

  task automatic finish_resp;
    @(posedge clk); #1 resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    @(negedge clk);
    tests++; if (job_ready !== 1'b1) begin fails++; $display("FAIL turnaround_job_ready: got %b want 1", job_ready); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++; if (job_ready !== 1'b1) begin fails++; $display("FAIL reset_job_ready: got %b want 1", job_ready); end
    tests++;
    if ({resp_valid, resp_count, resp_err, busy, mem_rd_en, mem_rd_addr, conv_start, conv_pixel,
         conv_pixel_valid, res_wr_en, res_wr_addr, res_wr_data} !== '0) begin
      fails++; $display("FAIL reset_outputs: busy %b rd_en %b pv %b wr_en %b resp %b, want all 0",
                        busy, mem_rd_en, conv_pixel_valid, res_wr_en, resp_valid);
    end
  endtask

  task automatic test_gap0;
    start_job(16'h0100, 16'h2000, 0, 900, 1'b1);
    wait_resp(1300);
    tests++; if (start_cyc !== acc + 1) begin fails++; $display("FAIL gap0_start_lat: got %0d want %0d", start_cyc - acc, 1); end
    tests++; if (first_rd !== acc + 2) begin fails++; $display("FAIL gap0_rd_lat: got %0d want %0d", first_rd - acc, 2); end
    tests++; if (pv_first !== acc + 3) begin fails++; $display("FAIL gap0_pv_lat: got %0d want %0d", pv_first - acc, 3); end
    tests++; if (rd_cnt !== 1024 || rd_bad !== 0) begin fails++; $display("FAIL gap0_reads: got %0d reads %0d bad want 1024/0", rd_cnt, rd_bad); end
    tests++; if (pv_max !== 1024) begin fails++; $display("FAIL gap0_pv_run: got %0d want 1024", pv_max); end
    tests++; if (pix_bad !== 0) begin fails++; $display("FAIL gap0_pixels: got %0d bad want 0", pix_bad); end
    tests++; if (wr_cnt !== 900 || wr_bad !== 0) begin fails++; $display("FAIL gap0_writes: got %0d writes %0d bad want 900/0", wr_cnt, wr_bad); end
    tests++; if (last_wr !== 16'h2383) begin fails++; $display("FAIL gap0_last_addr: got %h want 2383", last_wr); end
    tests++; if (resp_count !== 11'd900 || resp_err !== 2'b00) begin fails++; $display("FAIL gap0_resp: got %0d/%b want 900/00", resp_count, resp_err); end
    finish_resp();
  endtask

  task automatic test_gap3;
    start_job(16'h0100, 16'h2000, 3, 900, 1'b1);
    wait_resp(4400);
    tests++; if (rd_cnt !== 1024 || rd_bad !== 0) begin fails++; $display("FAIL gap3_reads: got %0d reads %0d bad want 1024/0", rd_cnt, rd_bad); end
    tests++; if (gap_bad !== 0) begin fails++; $display("FAIL gap3_spacing: got %0d bad gaps want 0", gap_bad); end
    tests++; if (pix_bad !== 0 || pv_cnt !== 1024) begin fails++; $display("FAIL gap3_pixels: got %0d/%0d want 1024/0", pv_cnt, pix_bad); end
    tests++; if (wr_cnt !== 900 || wr_bad !== 0) begin fails++; $display("FAIL gap3_writes: got %0d writes %0d bad want 900/0", wr_cnt, wr_bad); end
    tests++; if (resp_count !== 11'd900 || resp_err !== 2'b00) begin fails++; $display("FAIL gap3_resp: got %0d/%b want 900/00", resp_count, resp_err); end
    finish_resp();
  endtask

  task automatic test_timeout;
    start_job(16'h0300, 16'h1000, 0, 50, 1'b0);
    wait_resp(1300);
    tests++; if (resp_cyc - last_rd !== 73) begin fails++; $display("FAIL to_latency: got %0d want 73", resp_cyc - last_rd); end
    tests++; if (resp_count !== 11'd50 || resp_err !== 2'b01) begin fails++; $display("FAIL to_resp: got %0d/%b want 50/01", resp_count, resp_err); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++; if (resp_valid !== 1'b1 || resp_count !== 11'd50) begin fails++; $display("FAIL to_hold: got %b/%0d want 1/50", resp_valid, resp_count); end
    end
    finish_resp();
  endtask

  task automatic test_overflow;
    start_job(16'h0000, 16'h4000, 0, 1030, 1'b1);
    wait_resp(1300);
    tests++; if (wr_cnt !== 1024 || wr_bad !== 0) begin fails++; $display("FAIL ovf_writes: got %0d writes %0d bad want 1024/0", wr_cnt, wr_bad); end
    tests++; if (last_wr !== 16'h43FF) begin fails++; $display("FAIL ovf_last_addr: got %h want 43ff", last_wr); end
    tests++; if (resp_count !== 11'd1024 || resp_err !== 2'b10) begin fails++; $display("FAIL ovf_resp: got %0d/%b want 1024/10", resp_count, resp_err); end
    finish_resp();
  endtask

  task automatic test_reset_mid;
    int seen;
    start_job(16'h0500, 16'h3000, 0, 900, 1'b1);
    for (int i = 0; i < 1000 && rd_cnt < 500; i++) @(negedge clk);
    tests++; if (rd_cnt < 500) begin fails++; $display("FAIL mid_reach: got %0d reads want 500", rd_cnt); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if ({resp_valid, resp_count, resp_err, busy, mem_rd_en, mem_rd_addr, conv_start, conv_pixel,
         conv_pixel_valid, res_wr_en, res_wr_addr, res_wr_data} !== '0 || job_ready !== 1'b1) begin
      fails++; $display("FAIL mid_abort: busy %b rd_en %b pv %b wr_en %b ready %b want 0/0/0/0/1",
                        busy, mem_rd_en, conv_pixel_valid, res_wr_en, job_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    repeat (30) begin @(negedge clk); if (resp_valid) seen++; end
    tests++; if (seen !== 0) begin fails++; $display("FAIL mid_no_resp: got %0d resp cycles want 0", seen); end
    start_job(16'h0700, 16'h2000, 0, 900, 1'b1);
    wait_resp(1300);
    tests++; if (first_rd !== acc + 2 || rd_cnt !== 1024 || rd_bad !== 0) begin fails++; $display("FAIL mid_rerun_reads: lat %0d reads %0d bad %0d want 2/1024/0", first_rd - acc, rd_cnt, rd_bad); end
    tests++; if (wr_bad !== 0 || resp_count !== 11'd900 || resp_err !== 2'b00) begin fails++; $display("FAIL mid_rerun_resp: got %0d/%b bad %0d want 900/00/0", resp_count, resp_err, wr_bad); end
    finish_resp();
  endtask

  initial begin
    test_reset();
    test_gap0();
    test_gap3();
    test_timeout();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
